// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Function : Multi-cycle unsigned subtractor. Computes minuend - subtrahend
//            as a borrow-ripple chain over DIGIT_W bits per clock, with a
//            registered borrow carried between digits. Valid/ready handshake
//            on both the operand and the result side.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int                 c_digits     = WIDTH / DIGIT_W;
    localparam int                 c_cnt_w      = (c_digits > 1) ? $clog2(c_digits) : 1;
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_digits - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_borrow;
    logic                 r_bin;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DIGIT_W-1:0]   w_digit;
    logic                 w_bout;
    logic [WIDTH-1:0]     w_diff_next;
    logic                 w_accept;
    logic                 w_last;

    // rst is folded in so the block never advertises readiness while held in reset
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == c_last_digit);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Full-subtractor chain over the current digit (always the low bits of
    // the shifting operand registers), seeded by the registered borrow
    always_comb begin
        logic c;
        c       = r_bin;
        w_digit = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            w_digit[i] = r_a[i] ^ r_b[i] ^ c;
            c          = (~r_a[i] & r_b[i]) | (~r_a[i] & c) | (r_b[i] & c);
        end
        w_bout = c;
    end

    // Result digits enter at the top and shift down, so after the last digit
    // the LSB digit sits at bit 0
    generate
        if (DIGIT_W == WIDTH) begin : g_single_digit
            assign w_diff_next = w_digit;
        end else begin : g_multi_digit
            assign w_diff_next = {w_digit, r_diff[WIDTH-1:DIGIT_W]};
        end
    endgenerate

    // Operand latch, digit counter, borrow chaining and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a   <= minuend;
            r_b   <= subtrahend;
            r_bin <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a    <= r_a >> DIGIT_W;
            r_b    <= r_b >> DIGIT_W;
            r_bin  <= w_bout;
            r_cnt  <= r_cnt + c_cnt_w'(1);
            r_diff <= w_diff_next;
            if (w_last) begin
                r_borrow <= w_bout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Function : Directed bench for serial_subtractor, bit-serial (default) and
//            4-bit-digit instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv16, ir16, ov16, or16, b16;
    logic [15:0] a16, s16, d16;
    logic        iv4, ir4, ov4, or4, b4;
    logic [15:0] a4, s4, d4;

    int passed = 0;
    int total  = 0;

    serial_subtractor #(.WIDTH(16), .DIGIT_W(1)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .minuend(a16), .subtrahend(s16),
        .out_valid(ov16), .out_ready(or16),
        .diff(d16), .borrow(b16)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4),
        .minuend(a4), .subtrahend(s4),
        .out_valid(ov4), .out_ready(or4),
        .diff(d4), .borrow(b4)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        iv16 = 0; or16 = 1; a16 = '0; s16 = '0;
        iv4  = 0; or4  = 0; a4  = '0; s4  = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ir16 !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", ir16); else passed++;
        total++; if (ov16 !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", ov16); else passed++;
        total++; if (d16 !== 16'h0) $display("FAIL reset_diff got=%h want=0000", d16); else passed++;
        total++; if (b16 !== 1'b0) $display("FAIL reset_borrow got=%b want=0", b16); else passed++;
        total++; if (ir4 !== 1'b0) $display("FAIL reset_in_ready4 got=%b want=0", ir4); else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (ir16 !== 1'b1) $display("FAIL release_in_ready got=%b want=1", ir16); else passed++;
        total++; if (ir4 !== 1'b1) $display("FAIL release_in_ready4 got=%b want=1", ir4); else passed++;
    endtask

    // One full operation on the bit-serial instance with out_ready held high
    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic eb, input string nm);
        int lat;
        total++; if (ir16 !== 1'b1) $display("FAIL %s pre_in_ready got=%b want=1", nm, ir16); else passed++;
        a16 = a; s16 = b; iv16 = 1'b1;
        @(posedge clk);
        #1 iv16 = 1'b0; a16 = ~a; s16 = ~b;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        total++; if (lat != 16) $display("FAIL %s latency got=%0d want=16", nm, lat); else passed++;
        total++; if (d16 !== ed) $display("FAIL %s diff got=%h want=%h", nm, d16, ed); else passed++;
        total++; if (b16 !== eb) $display("FAIL %s borrow got=%b want=%b", nm, b16, eb); else passed++;
        @(posedge clk); #1;
        total++; if (ir16 !== 1'b1) $display("FAIL %s post_in_ready got=%b want=1", nm, ir16); else passed++;
        total++; if (ov16 !== 1'b0) $display("FAIL %s post_out_valid got=%b want=0", nm, ov16); else passed++;
    endtask

    task automatic test_basic();
        run16(16'h1234, 16'h0034, 16'h1200, 1'b0, "basic");
    endtask

    task automatic test_wrap();
        run16(16'h0000, 16'h0001, 16'hFFFF, 1'b1, "wrap_0_1");
        run16(16'h8000, 16'h8000, 16'h0000, 1'b0, "eq_8000");
        run16(16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, "ffff_0");
    endtask

    task automatic test_backpressure();
        int lat;
        or16 = 1'b0;
        a16 = 16'h4321; s16 = 16'h1111; iv16 = 1'b1;
        @(posedge clk);
        #1 iv16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 a16 = 16'h0000; s16 = 16'hFFFF; iv16 = 1'b1;
        @(posedge clk);
        #1 iv16 = 1'b0;
        lat = 4;
        while (ov16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        total++; if (lat != 16) $display("FAIL bp_latency got=%0d want=16", lat); else passed++;
        iv16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (ov16 !== 1'b1 || ir16 !== 1'b0)
                $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b want 1/0", i, ov16, ir16);
            else passed++;
            total++; if (d16 !== 16'h3210 || b16 !== 1'b0)
                $display("FAIL bp_stable cyc=%0d diff=%h borrow=%b want 3210/0", i, d16, b16);
            else passed++;
        end
        iv16 = 1'b0; or16 = 1'b1;
        @(posedge clk); #1;
        total++; if (ir16 !== 1'b1 || ov16 !== 1'b0)
            $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", ir16, ov16);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int seen;
        a16 = 16'h00FF; s16 = 16'h0100; iv16 = 1'b1;
        @(posedge clk);
        #1 iv16 = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (ov16 !== 1'b0 || d16 !== 16'h0 || b16 !== 1'b0)
            $display("FAIL midreset_outputs ov=%b diff=%h borrow=%b want 0/0000/0", ov16, d16, b16);
        else passed++;
        total++; if (ir16 !== 1'b0) $display("FAIL midreset_in_ready got=%b want=0", ir16); else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov16 === 1'b1) seen++;
        end
        total++; if (seen != 0) $display("FAIL midreset_ghost out_valid_cycles got=%0d want=0", seen); else passed++;
        run16(16'h0005, 16'h0003, 16'h0002, 1'b0, "after_reset");
    endtask

    task automatic test_digit4();
        int lat;
        logic [16:0] exp;
        logic [15:0] a, b;
        or4 = 1'b0;
        a4 = 16'h1000; s4 = 16'h0001; iv4 = 1'b1;
        @(posedge clk);
        #1 iv4 = 1'b0;
        lat = 0;
        while (ov4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total++; if (lat != 4) $display("FAIL d4_latency got=%0d want=4", lat); else passed++;
        total++; if (d4 !== 16'h0FFF || b4 !== 1'b0)
            $display("FAIL d4_ripple diff=%h borrow=%b want 0fff/0", d4, b4);
        else passed++;
        or4 = 1'b1;
        @(posedge clk); #1 or4 = 1'b0;
        total++; if (ir4 !== 1'b1) $display("FAIL d4_in_ready got=%b want=1", ir4); else passed++;
        for (int n = 0; n < 200; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            exp = {1'b0, a} - {1'b0, b};
            a4 = a; s4 = b; iv4 = 1'b1;
            @(posedge clk);
            #1 iv4 = 1'b0; a4 = ~a; s4 = ~b;
            lat = 0;
            while (ov4 !== 1'b1 && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            total++; if ({b4, d4} !== exp || lat != 4)
                $display("FAIL d4_rand n=%0d a=%h b=%h got=%b_%h lat=%0d want=%b_%h lat=4",
                         n, a, b, b4, d4, lat, exp[16], exp[15:0]);
            else passed++;
            or4 = 1'b1;
            @(posedge clk); #1 or4 = 1'b0;
        end
        total++; if (ir4 !== 1'b1) $display("FAIL d4_final_in_ready got=%b want=1", ir4); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_digit4();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
